mux8_rr_arb: RTL
================

MUX8_RR_ARB -- requirements
Module: mux8_rr_arb

Interface
REQ-001 Parameter: MAX_HOLD, 8, max consecutive GRANT cycles per owner (legal 1..15).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  8  request vector; bit i = source a_i requests the shared 8:1 mux output.
REQ-005 Port: gnt  output  8  one-hot grant; all-zero when no owner.
REQ-006 Port: sel  output  3  mux select, binary index of owner; sel[0]=s0, sel[1]=s1, sel[2]=s2 of mux8.
REQ-007 Port: valid  output  1  high when gnt is non-zero, i.e. mux output belongs to an owner.
REQ-008 Port: owner_hold  output  4  GRANT cycles consumed by current owner, 0 when idle.

Function
REQ-009 All outputs SHALL be registered; no combinational path from req to any output.
REQ-010 FSM states SHALL be IDLE, GRANT, GAP.
REQ-011 IDLE: if req != 0 at a clock edge, SHALL enter GRANT on that edge with winner registered; else stay IDLE.
REQ-012 Winner SHALL be first set req bit searching upward from (last+1) mod 8, wrapping 7->0; last = index of previous winner.
REQ-013 Grant latency SHALL be exactly 1 cycle: req sampled at edge N, gnt/sel/valid visible after edge N.
REQ-014 On entering GRANT: gnt = 1<<winner, sel = winner, valid = 1, owner_hold = 1, last = winner.
REQ-015 GRANT: each edge with req[owner]=1 and owner_hold < MAX_HOLD SHALL hold grant and increment owner_hold.
REQ-016 GRANT: edge with req[owner]=0 SHALL release: enter GAP.
REQ-017 GRANT: edge with owner_hold == MAX_HOLD SHALL release into GAP regardless of req[owner] (forced rotation).
REQ-018 GAP: gnt = 0, valid = 0, owner_hold = 0, sel SHALL hold last value; exactly one cycle, then IDLE (break-before-make).
REQ-019 Changes to non-owner req bits during GRANT SHALL not affect gnt or sel.
REQ-020 gnt SHALL never have more than one bit set; sel SHALL always equal index of set gnt bit when valid = 1.
REQ-021 A source re-requesting immediately after release SHALL win only if no other req bit is set between it and last in round-robin order.
REQ-022 Single requester continuously asserting SHALL get MAX_HOLD cycles, one GAP, one IDLE, then re-grant (period MAX_HOLD+2).
REQ-023 owner_hold SHALL saturate at MAX_HOLD and never wrap.

Reset
REQ-024 rst_n low SHALL immediately (asynchronously) force state IDLE, gnt = 0, sel = 0, valid = 0, owner_hold = 0, last = 7.
REQ-025 rst_n low mid-GRANT SHALL drop grant in the same cycle without passing through GAP.
REQ-026 After rst_n release, first edge with req != 0 SHALL grant lowest set index (search starts at 0).

Verification
REQ-027 Reset then req=8'h81 held -> edge+1: gnt=8'h01, sel=0; after release req=8'h80 -> next grant gnt=8'h80, sel=7.
REQ-028 req=8'hFF held, MAX_HOLD=8 -> grants rotate sel 0,1,2,...,7,0; each owner valid 8 cycles, each followed by 1 GAP + 1 IDLE cycle.
REQ-029 Owner sel=3, req[3] drops after 2 cycles while req=8'h24 -> GAP, IDLE, then gnt=8'h20, sel=5 (not 2).
REQ-030 Only req[6] held continuously, MAX_HOLD=8 -> valid pattern 8 high, 2 low, repeat; sel=6 throughout; owner_hold counts 1..8.
REQ-031 rst_n pulsed low mid-GRANT (owner 4) -> gnt=0, valid=0, sel=0 within same cycle; with req=8'h10 after release -> gnt=8'h10 one cycle later.
REQ-032 All cases: assert gnt one-hot-or-zero, valid == |gnt, sel matches gnt, and mux8 y equals a[sel] whenever valid=1.

Source files
------------

// File: rtl/mux8_rr_arb.sv
// Round-robin arbiter driving the select of a shared 8:1 mux.
// A requester that wins is granted for up to MAX_HOLD cycles. Every release
// goes through a one-cycle GAP (grant low) and then IDLE, so two owners never
// drive the mux back to back. All outputs come straight from flops.
//
// Handshake: req[i] is a level request from source i. gnt/sel/valid reflect the
// arbitration result one cycle after req is sampled. An owner keeps the grant
// while its req bit stays high and its hold budget lasts. Dropping req releases
// the grant. Requests from non-owners are only looked at in IDLE.
module mux8_rr_arb #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       valid,
    output logic [3:0] owner_hold
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] sel_q, sel_d;
    logic       valid_q, valid_d;
    logic [3:0] hold_q, hold_d;
    logic [2:0] last_q, last_d;

    logic       win_found;
    logic [2:0] win_idx;
    logic [2:0] cand;

    // Round-robin search: first set req bit starting just above the last winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q + 3'd1;
        cand      = last_q + 3'd1;
        for (int k = 0; k < 8; k++) begin
            cand = last_q + 3'd1 + 3'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and next-output computation for the IDLE/GRANT/GAP machine.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        hold_d  = hold_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = GRANT;
                    gnt_d   = 8'd1 << win_idx;
                    sel_d   = win_idx;
                    valid_d = 1'b1;
                    hold_d  = 4'd1;
                    last_d  = win_idx;
                end
            end
            GRANT: begin
                // Budget exhaustion forces rotation even if the owner still asks.
                if (hold_q >= HOLD_MAX || !req[sel_q]) begin
                    state_d = GAP;
                    gnt_d   = 8'd0;
                    valid_d = 1'b0;
                    hold_d  = 4'd0;
                end else begin
                    hold_d  = hold_q + 4'd1;
                end
            end
            GAP: begin
                // sel keeps pointing at the previous owner while the mux is idle.
                state_d = IDLE;
                gnt_d   = 8'd0;
                valid_d = 1'b0;
                hold_d  = 4'd0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 8'd0;
                valid_d = 1'b0;
                hold_d  = 4'd0;
            end
        endcase
    end

    // State and output registers; reset drops the grant immediately and
    // points last at 7 so the first search begins at index 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 8'd0;
            sel_q   <= 3'd0;
            valid_q <= 1'b0;
            hold_q  <= 4'd0;
            last_q  <= 3'd7;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
        end
    end

    assign gnt        = gnt_q;
    assign sel        = sel_q;
    assign valid      = valid_q;
    assign owner_hold = hold_q;

endmodule
